// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter: round-robin arbiter sharing one FIFO write port among NREQ valid/ready/last streams
module fifo_wr_arbiter #(
  parameter int WIDTH     = 8,
  parameter int NREQ      = 4,
  parameter int MAX_BURST = 16
) (
  input  logic                    wr_clk,
  input  logic                    wr_rstn,
  input  logic [NREQ-1:0]         req_valid,
  input  logic [NREQ*WIDTH-1:0]   req_data,
  input  logic [NREQ-1:0]         req_last,
  output logic [NREQ-1:0]         req_ready,
  input  logic                    fifo_full,
  output logic                    fifo_wr_en,
  output logic [WIDTH-1:0]        fifo_wr_data,
  output logic [$clog2(NREQ)-1:0] grant_id,
  output logic                    busy,
  output logic                    burst_cut
);
  localparam int IW = $clog2(NREQ);
  localparam int CW = $clog2(MAX_BURST + 1);
  typedef enum logic {IDLE, LOCK} state_t;
  state_t state, state_nxt;
  logic [IW-1:0] rr_last, winner, idx;
  logic [CW-1:0] beat_cnt;
  logic at_limit, release_beat, cut_nxt;
  assign busy     = state == LOCK;
  assign at_limit = beat_cnt == CW'(MAX_BURST - 1);
  assign cut_nxt  = release_beat & ~req_last[grant_id];
  // nearest valid requester above rr_last, wrapping; smallest distance is assigned last and wins
  always_comb begin
    winner = rr_last;
    idx = '0;
    for (int k = NREQ; k >= 1; k--) begin
      idx = IW'((int'(rr_last) + k) % NREQ);
      winner = req_valid[idx] ? idx : winner;
    end
  end
  // write data always follows the current or last granted requester
  always_comb begin
    fifo_wr_data = req_data[WIDTH-1:0];
    for (int i = 1; i < NREQ; i++)
      fifo_wr_data = (grant_id == IW'(i)) ? req_data[i*WIDTH +: WIDTH] : fifo_wr_data;
  end
  // next state plus the combinational LOCK-phase handshake; fifo_full gates it with no register
  always_comb begin
    state_nxt = state;
    req_ready = '0;
    fifo_wr_en = 1'b0;
    release_beat = 1'b0;
    if (state == IDLE) begin
      state_nxt = |req_valid ? LOCK : IDLE;
    end else begin
      req_ready[grant_id] = ~fifo_full;
      fifo_wr_en = req_valid[grant_id] & ~fifo_full;
      release_beat = fifo_wr_en & (req_last[grant_id] | at_limit);
      state_nxt = release_beat ? IDLE : LOCK;
    end
  end
  // state register
  always_ff @(posedge wr_clk or negedge wr_rstn) begin
    if (!wr_rstn) state <= IDLE;
    else state <= state_nxt;
  end
  // grant capture, round-robin pointer, per-grant beat count and registered cut pulse
  always_ff @(posedge wr_clk or negedge wr_rstn) begin
    if (!wr_rstn) begin
      grant_id  <= '0;
      rr_last   <= IW'(NREQ - 1);
      beat_cnt  <= '0;
      burst_cut <= 1'b0;
    end else begin
      burst_cut <= cut_nxt;
      if (state == IDLE) begin
        if (|req_valid) begin
          grant_id <= winner;
          beat_cnt <= '0;
        end
      end else if (release_beat) begin
        rr_last  <= grant_id;
        beat_cnt <= '0;
      end else if (fifo_wr_en) begin
        beat_cnt <= beat_cnt + CW'(1);
      end
    end
  end
endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// tb_fifo_wr_arbiter: scoreboard bench with a packet-level requester model and directed plus random traffic
module tb_fifo_wr_arbiter;
  localparam int WIDTH = 8, NREQ = 4, MAX_BURST = 16, IW = 2;
  logic wr_clk = 1'b0, wr_rstn = 1'b0;
  logic [NREQ-1:0] req_valid = '0, req_last = '0, req_ready;
  logic [NREQ*WIDTH-1:0] req_data = '0;
  logic fifo_full = 1'b0, fifo_wr_en, busy, burst_cut;
  logic [WIDTH-1:0] fifo_wr_data;
  logic [IW-1:0] grant_id;

  fifo_wr_arbiter #(.WIDTH(WIDTH), .NREQ(NREQ), .MAX_BURST(MAX_BURST)) dut (
    .wr_clk(wr_clk), .wr_rstn(wr_rstn), .req_valid(req_valid), .req_data(req_data),
    .req_last(req_last), .req_ready(req_ready), .fifo_full(fifo_full), .fifo_wr_en(fifo_wr_en),
    .fifo_wr_data(fifo_wr_data), .grant_id(grant_id), .busy(busy), .burst_cut(burst_cut)
  );

  always #5 wr_clk = ~wr_clk;

  typedef struct packed {
    logic wr_en;
    logic [WIDTH-1:0] data;
    logic [NREQ-1:0] ready;
    logic busy;
    logic [IW-1:0] gid;
    logic cut;
  } stat_t;

  stat_t stat_q[$];
  logic [WIDTH-1:0] wr_q[$];
  int dut_g[$], exp_g[$];
  int checks = 0, errors = 0, wr_cnt = 0, cut_cnt = 0;
  logic prev_busy = 1'b0;

  logic [WIDTH:0] beats [NREQ][1024];
  int head[NREQ] = '{default: 0};
  int tail[NREQ] = '{default: 0};

  int m_owner = -1, m_gid = 0, m_rr = NREQ - 1, m_beats = 0;
  bit m_cut = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic add_pkt(input int r, input int len);
    for (int b = 0; b < len; b++) begin
      beats[r][tail[r]] = {b == len - 1, WIDTH'($urandom)};
      tail[r]++;
    end
  endtask

  function automatic bit pending();
    for (int i = 0; i < NREQ; i++) if (head[i] != tail[i]) return 1'b1;
    return 1'b0;
  endfunction

  // one cycle of the arbiter as seen from the requesters and the FIFO
  task automatic model_cycle();
    stat_t s;
    bit we, l;
    we = m_owner >= 0 && req_valid[m_owner] && !fifo_full;
    s.wr_en = we;
    s.data = req_data[m_gid*WIDTH +: WIDTH];
    s.ready = (m_owner >= 0 && !fifo_full) ? NREQ'(1 << m_owner) : '0;
    s.busy = m_owner >= 0;
    s.gid = IW'(m_gid);
    s.cut = m_cut;
    stat_q.push_back(s);
    if (we) wr_q.push_back(req_data[m_owner*WIDTH +: WIDTH]);
    m_cut = 1'b0;
    if (m_owner < 0) begin
      for (int k = NREQ; k >= 1; k--) if (req_valid[(m_rr + k) % NREQ]) m_owner = (m_rr + k) % NREQ;
      if (m_owner >= 0) begin
        m_gid = m_owner;
        m_beats = 0;
      end
    end else if (we) begin
      m_beats++;
      l = req_last[m_owner];
      head[m_owner]++;
      if (l || m_beats == MAX_BURST) begin
        m_cut = !l;
        m_rr = m_owner;
        m_owner = -1;
        m_beats = 0;
      end
    end
  endtask

  task automatic step(input logic [NREQ-1:0] g, input bit f);
    @(negedge wr_clk);
    for (int i = 0; i < NREQ; i++) begin
      if (head[i] != tail[i]) begin
        req_valid[i] = g[i];
        req_data[i*WIDTH +: WIDTH] = beats[i][head[i]][WIDTH-1:0];
        req_last[i] = beats[i][head[i]][WIDTH];
      end else begin
        req_valid[i] = 1'b0;
        req_last[i] = 1'($urandom_range(1));
        req_data[i*WIDTH +: WIDTH] = WIDTH'($urandom);
      end
    end
    fifo_full = f;
    model_cycle();
  endtask

  task automatic run(input int n, input logic [NREQ-1:0] g, input bit f);
    repeat (n) step(g, f);
  endtask

  task automatic drain();
    int n = 0;
    while ((pending() || m_owner >= 0) && n < 3000) begin
      step('1, 1'b0);
      n++;
    end
    checks++;
    if (n >= 3000) begin
      errors++;
      $display("FAIL drain_timeout: traffic still pending after %0d cycles, required 0", n);
    end
    run(2, '1, 1'b0);
    #5;
  endtask

  task automatic push_reset_rec();
    stat_t s;
    s.wr_en = 1'b0;
    s.data = req_data[WIDTH-1:0];
    s.ready = '0;
    s.busy = 1'b0;
    s.gid = '0;
    s.cut = 1'b0;
    stat_q.push_back(s);
  endtask

  task automatic do_reset(input int n);
    @(negedge wr_clk);
    #2 wr_rstn = 1'b0;
    #1;
    chk("rst_async_busy", busy, 0);
    chk("rst_async_wr_en", fifo_wr_en, 0);
    for (int i = 0; i < NREQ; i++) head[i] = tail[i];
    req_valid = '0;
    req_last = '0;
    push_reset_rec();
    m_owner = -1; m_gid = 0; m_rr = NREQ - 1; m_beats = 0; m_cut = 1'b0;
    repeat (n - 1) begin
      @(negedge wr_clk);
      push_reset_rec();
    end
    @(negedge wr_clk);
    wr_rstn = 1'b1;
    model_cycle();
  endtask

  task automatic chk_grants(input string name);
    chk({name, "_count"}, dut_g.size(), exp_g.size());
    for (int i = 0; i < exp_g.size() && i < dut_g.size(); i++) chk(name, dut_g[i], exp_g[i]);
    dut_g.delete();
  endtask

  // monitor: pops the expected cycle record and the expected write stream independently of stimulus
  initial begin
    stat_t s;
    forever begin
      @(negedge wr_clk);
      #4;
      if (stat_q.size() > 0) begin
        s = stat_q.pop_front();
        chk("wr_en", fifo_wr_en, s.wr_en);
        chk("busy", busy, s.busy);
        chk("req_ready", req_ready, s.ready);
        chk("grant_id", grant_id, s.gid);
        chk("burst_cut", burst_cut, s.cut);
        chk("wr_data_mux", fifo_wr_data, s.data);
        if (fifo_wr_en) begin
          wr_cnt++;
          if (wr_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL wr_unexpected: got write %0h, required none", fifo_wr_data);
          end else chk("wr_stream", fifo_wr_data, wr_q.pop_front());
        end
        if (busy && !prev_busy) dut_g.push_back(int'(grant_id));
        if (burst_cut) cut_cnt++;
        prev_busy = busy;
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1);
  end

  initial begin
    int w0, w1, c0, added;
    logic [NREQ-1:0] g;
    req_data = 32'hA5C3_5A17;
    #3;
    chk("reset_busy", busy, 0);
    chk("reset_wr_en", fifo_wr_en, 0);
    chk("reset_ready", req_ready, 0);
    chk("reset_grant", grant_id, 0);
    chk("reset_cut", burst_cut, 0);
    chk("reset_data", fifo_wr_data, 8'h17);
    @(negedge wr_clk);
    wr_rstn = 1'b1;

    w0 = wr_cnt;
    add_pkt(2, 3);
    drain();
    exp_g = {2};
    chk_grants("t1_grant");
    chk("t1_writes", wr_cnt - w0, 3);

    do_reset(2);
    w0 = wr_cnt;
    for (int p = 0; p < 2; p++) for (int i = 0; i < NREQ; i++) add_pkt(i, 1);
    drain();
    exp_g = {0, 1, 2, 3, 0, 1, 2, 3};
    chk_grants("t2_order");
    chk("t2_writes", wr_cnt - w0, 8);

    w0 = wr_cnt;
    c0 = cut_cnt;
    add_pkt(1, 5);
    run(3, '1, 1'b0);
    run(4, '1, 1'b1);
    drain();
    exp_g = {1};
    chk_grants("t3_grant");
    chk("t3_writes", wr_cnt - w0, 5);
    chk("t3_cuts", cut_cnt - c0, 0);

    w0 = wr_cnt;
    c0 = cut_cnt;
    add_pkt(0, 20);
    add_pkt(3, 2);
    run(1, 4'b0001, 1'b0);
    drain();
    exp_g = {0, 3, 0};
    chk_grants("t4_order");
    chk("t4_writes", wr_cnt - w0, 22);
    chk("t4_cuts", cut_cnt - c0, 1);

    w0 = wr_cnt;
    add_pkt(3, 4);
    run(2, '1, 1'b0);
    do_reset(2);
    add_pkt(0, 1);
    add_pkt(3, 1);
    drain();
    exp_g = {3, 0, 3};
    chk_grants("t5_order");
    chk("t5_writes", wr_cnt - w0, 3);

    w0 = wr_cnt;
    add_pkt(1, 4);
    add_pkt(2, 1);
    run(1, 4'b0010, 1'b0);
    run(2, 4'b0110, 1'b0);
    #5;
    w1 = wr_cnt;
    run(3, 4'b0100, 1'b0);
    #5;
    chk("t6_gap_writes", wr_cnt - w1, 0);
    drain();
    exp_g = {1, 2};
    chk_grants("t6_order");
    chk("t6_writes", wr_cnt - w0, 5);

    w0 = wr_cnt;
    added = 0;
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < NREQ; i++) begin
        if ($urandom_range(99) < 6 && tail[i] - head[i] < 24 && tail[i] < 980) begin
          int len = $urandom_range(20, 1);
          add_pkt(i, len);
          added += len;
        end
        g[i] = $urandom_range(99) < 75;
      end
      step(g, $urandom_range(99) < 20);
    end
    drain();
    dut_g.delete();
    chk("rand_writes", wr_cnt - w0, added);
    chk("stat_q_drained", stat_q.size(), 0);
    chk("wr_q_drained", wr_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
